// File: rtl/x1_dpram_pkg.sv
// Shared constants and read-engine state encoding for the 1k x 16 dual-port RAM.
package x1_dpram_pkg;
  localparam int DPRAM_AW    = 10;
  localparam int DPRAM_DW    = 16;
  localparam int DPRAM_WORDS = 1024;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} rd_state_t;
endpackage

// File: rtl/stream_sync_fifo.sv
// Single-clock FIFO with occupancy count, synchronous flush and a registered head word.
module stream_sync_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [DW-1:0]            din_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
  logic [PW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]              cnt_q, cnt_d;
  logic [DW-1:0]            head_q;
  logic                     do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = din_i;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) rd_d = rd_q + PW'(1);
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Head is precomputed from next-state storage so a word pushed into an
  // empty FIFO is presented one cycle later, and stays put while stalled.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mem_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= mem_d[rd_d];
    end
  end

  assign dout_o  = head_q;
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/dpram_stream_reader.sv
// Port-B read engine: streams LEN words from BASE (wrapping) out of the dual-port RAM
// onto a valid/ready interface at one word per clock.
module dpram_stream_reader
  import x1_dpram_pkg::*;
#(
  parameter int AW         = DPRAM_AW,
  parameter int DW         = DPRAM_DW,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW:0]   len_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] ba_o,
  output logic          bcs_o,
  output logic          bwe_o,
  output logic [DW-1:0] bi_o,
  input  logic [DW-1:0] bo_i,
  output logic [DW-1:0] dout_o,
  output logic          dvalid_o,
  input  logic          dready_i
);
  localparam int          CW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

  rd_state_t     state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   issue_q, pop_q;
  logic          rd_vld_q, busy_q, done_q;

  logic [AW:0]   len_c;
  logic [CW:0]   fifo_cnt;
  logic [CW+1:0] occ;
  logic          kill, pop, push;

  assign len_c = (len_i > MAX_LEN) ? MAX_LEN : len_i;
  assign kill  = abort_i && (state_q != IDLE);
  // Reserve a slot for every read still in flight so the FIFO cannot overflow.
  assign occ   = {1'b0, fifo_cnt} + {{(CW+1){1'b0}}, rd_vld_q};
  assign bcs_o = (state_q == READ) && (issue_q != '0) && (occ < (CW+2)'(FIFO_DEPTH));
  assign pop   = dvalid_o && dready_i;
  assign push  = rd_vld_q && !kill;

  assign ba_o   = addr_q;
  assign bwe_o  = 1'b0;
  assign bi_o   = '0;
  assign busy_o = busy_q;
  assign done_o = done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      issue_q  <= '0;
      pop_q    <= '0;
      rd_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= bcs_o && !kill;
      case (state_q)
        IDLE: begin
          if (start_i && !abort_i) begin
            addr_q  <= base_i;
            issue_q <= len_c;
            pop_q   <= len_c;
            if (len_c != '0) begin
              state_q <= READ;
              busy_q  <= 1'b1;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            issue_q <= '0;
            pop_q   <= '0;
          end else begin
            if (bcs_o) begin
              addr_q  <= addr_q + AW'(1);
              issue_q <= issue_q - (AW+1)'(1);
              if (issue_q == (AW+1)'(1)) state_q <= DRAIN;
            end
            // The final pop always lands in DRAIN: data trails the last issue by two cycles.
            if (pop) begin
              pop_q <= pop_q - (AW+1)'(1);
              if (pop_q == (AW+1)'(1)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  stream_sync_fifo #(
    .DW   (DW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .flush_i(kill),
    .push_i (push),
    .din_i  (bo_i),
    .pop_i  (pop),
    .dout_o (dout_o),
    .valid_o(dvalid_o),
    .count_o(fifo_cnt)
  );
endmodule
